// File: rtl/core_debug_ctrl.sv
// Debug sequencer for the RV32 core: takes halt/run/step/dump commands from the host link,
// drives the core's debug pins, and streams a scan of debug addresses back out.
module core_debug_ctrl #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int SCAN_LAST  = 127,
    parameter int CNT_W      = 16,
    parameter bit RESET_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_n,
    output logic              debug_en,
    output logic              debug_step,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_RUN,
        S_HALT,
        S_STEP_HI,
        S_STEP_LO,
        S_DUMP_ADDR,
        S_DUMP_OUT
    } state_t;

    localparam logic [1:0]        OP_HALT = 2'd0;
    localparam logic [1:0]        OP_RUN  = 2'd1;
    localparam logic [1:0]        OP_STEP = 2'd2;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SCAN_LAST);
    localparam state_t RESET_STATE = RESET_HALT ? S_HALT : S_RUN;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;

    // Everything the core and host see is decoded from the registered state.
    assign cmd_ready  = (state == S_RUN) || (state == S_HALT);
    assign busy       = !cmd_ready;
    assign debug_en   = (state != S_RUN);
    assign debug_step = (state == S_STEP_HI);
    assign debug_addr = ((state == S_DUMP_ADDR) || (state == S_DUMP_OUT)) ? addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            count      <= '0;
            addr       <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state)
                S_RUN, S_HALT: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_HALT: state <= S_HALT;
                            OP_RUN:  state <= S_RUN;
                            OP_STEP: begin
                                if (cmd_n == '0) begin
                                    state <= S_HALT;
                                end else begin
                                    count <= cmd_n;
                                    state <= S_STEP_HI;
                                end
                            end
                            default: begin
                                addr  <= '0;
                                state <= S_DUMP_ADDR;
                            end
                        endcase
                    end
                end
                S_STEP_HI: state <= S_STEP_LO;
                S_STEP_LO: begin
                    count <= count - 1'b1;
                    state <= (count == CNT_W'(1)) ? S_HALT : S_STEP_HI;
                end
                // The core presents data for debug_addr in the same cycle, so capture it here.
                S_DUMP_ADDR: begin
                    dump_data  <= debug_data;
                    dump_addr  <= addr;
                    dump_valid <= 1'b1;
                    state      <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (addr == LAST) begin
                            addr  <= '0;
                            state <= S_HALT;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= S_DUMP_ADDR;
                        end
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Self-checking bench for core_debug_ctrl: directed and randomized commands checked against
// a behavioural model of halt/run mode, step pulse timing and dump word ordering.
module tb_core_debug_ctrl;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int SCAN_LAST = 3;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [CNT_W-1:0]  cmd_n = '0;
    logic              debug_en;
    logic              debug_step;
    logic [ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0] debug_data;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              busy;

    logic [DATA_W-1:0] mem [0:127];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  model_halted = 1'b0;

    core_debug_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_LAST(SCAN_LAST),
        .CNT_W(CNT_W), .RESET_HALT(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_n(cmd_n),
        .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
        .debug_data(debug_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core model: debug data is a combinational read of a small memory
    assign debug_data = mem[debug_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " debug_en"},   32'(debug_en),   32'(model_halted));
        checkOutput({tag, " cmd_ready"},  32'(cmd_ready),  32'd1);
        checkOutput({tag, " busy"},       32'(busy),       32'd0);
        checkOutput({tag, " debug_step"}, 32'(debug_step), 32'd0);
        checkOutput({tag, " dump_valid"}, 32'(dump_valid), 32'd0);
        checkOutput({tag, " debug_addr"}, 32'(debug_addr), 32'd0);
    endtask

    task automatic fillMem(input bit rnd);
        for (int i = 0; i < 128; i++) mem[i] = rnd ? $urandom : (32'h100 + 32'(i));
    endtask

    // Expected dump protocol: one address cycle per word, then the word is offered until taken
    task automatic runDump(input int stall_word, input int stall_len, input bit rnd_ready);
        int idx = 0;
        int stall = 0;
        int budget = 0;
        bit exp_valid = 1'b0;
        bit rdy;
        while (idx <= SCAN_LAST && budget < 300) begin
            checkOutput("dump debug_addr", 32'(debug_addr), 32'(idx));
            checkOutput("dump valid",      32'(dump_valid), 32'(exp_valid));
            checkOutput("dump busy",       32'(busy),       32'd1);
            checkOutput("dump debug_en",   32'(debug_en),   32'd1);
            if (exp_valid) begin
                checkOutput("dump_addr", 32'(dump_addr), 32'(idx));
                checkOutput("dump_data", dump_data, mem[idx]);
            end
            if (exp_valid && idx == stall_word && stall < stall_len) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            dump_ready = rdy;
            tick();
            budget++;
            if (exp_valid && rdy) begin
                idx++;
                exp_valid = 1'b0;
            end else if (!exp_valid) begin
                exp_valid = 1'b1;
            end
        end
        checkOutput("dump word count", 32'(idx), 32'(SCAN_LAST + 1));
        dump_ready   = 1'b0;
        model_halted = 1'b1;
        checkIdle("after dump");
    endtask

    // Issue one command while idle and check the full response against the model
    task automatic applyStimulus(input logic [1:0] op, input int n, input int stall_word,
                                 input int stall_len, input bit rnd_ready);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_n     = CNT_W'(n);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_n     = CNT_W'($urandom);
        case (op)
            2'd0: begin model_halted = 1'b1; checkIdle("halt"); end
            2'd1: begin model_halted = 1'b0; checkIdle("run"); end
            2'd2: begin
                for (int k = 1; k <= 2 * n; k++) begin
                    checkOutput("step pulse",    32'(debug_step), 32'(k % 2));
                    checkOutput("step busy",     32'(busy),       32'd1);
                    checkOutput("step ready",    32'(cmd_ready),  32'd0);
                    checkOutput("step debug_en", 32'(debug_en),   32'd1);
                    tick();
                end
                model_halted = 1'b1;
                checkIdle("after step");
            end
            default: runDump(stall_word, stall_len, rnd_ready);
        endcase
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fillMem(1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_halted = 1'b0;
        checkIdle("reset");
        checkOutput("reset dump_addr", 32'(dump_addr), 32'd0);
        checkOutput("reset dump_data", dump_data, 32'd0);

        applyStimulus(2'd2, 3, -1, 0, 1'b0);
        applyStimulus(2'd2, 0, -1, 0, 1'b0);
        applyStimulus(2'd1, 0, -1, 0, 1'b0);
        applyStimulus(2'd1, 0, -1, 0, 1'b0);
        applyStimulus(2'd3, 0, -1, 0, 1'b0);
        applyStimulus(2'd1, 0, -1, 0, 1'b0);
        applyStimulus(2'd3, 0, 1, 5, 1'b0);

        // RUN held on the link while a two-pulse step runs
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_n     = CNT_W'(2);
        tick();
        cmd_op = 2'd1;
        cmd_n  = CNT_W'(7);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("wait ready", 32'(cmd_ready),  32'd0);
            checkOutput("wait pulse", 32'(debug_step), 32'(k % 2));
            tick();
        end
        checkOutput("wait ready back", 32'(cmd_ready), 32'd1);
        checkOutput("wait still halted", 32'(debug_en), 32'd1);
        tick();
        cmd_valid    = 1'b0;
        model_halted = 1'b0;
        checkIdle("run after step");

        // Reset while word 2 of a dump is being offered
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        tick();
        cmd_valid  = 1'b0;
        dump_ready = 1'b1;
        for (int k = 1; k < 6; k++) tick();
        dump_ready = 1'b0;
        checkOutput("pre-reset valid", 32'(dump_valid), 32'd1);
        checkOutput("pre-reset addr",  32'(dump_addr),  32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_halted = 1'b0;
        checkIdle("mid-dump reset");
        checkOutput("mid-dump reset dump_addr", 32'(dump_addr), 32'd0);
        dump_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("no dump after reset", 32'(dump_valid), 32'd0);
            checkOutput("run after reset",     32'(debug_en),   32'd0);
        end
        dump_ready = 1'b0;

        for (int it = 0; it < 30; it++) begin
            logic [1:0] op;
            int gap;
            op  = 2'($urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                checkIdle("random gap");
            end
            if (op == 2'd3) fillMem(1'b1);
            applyStimulus(op, $urandom_range(0, 5), $urandom_range(0, SCAN_LAST),
                          $urandom_range(0, 4), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
